// File: rtl/conv_pkg.sv
// Constants shared between the window generator and the 3x3 convolution core.
// Window elements are numbered row-major from top-left (0) to bottom-right (8).
package conv_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned WIN_W  = 9 * DATA_W;

  localparam int unsigned WIN_TL = 0;
  localparam int unsigned WIN_TC = 1;
  localparam int unsigned WIN_TR = 2;
  localparam int unsigned WIN_ML = 3;
  localparam int unsigned WIN_MC = 4;
  localparam int unsigned WIN_MR = 5;
  localparam int unsigned WIN_BL = 6;
  localparam int unsigned WIN_BC = 7;
  localparam int unsigned WIN_BR = 8;

  // Element 0 sits in the most significant slot of the packed window.
  function automatic int unsigned win_lsb(input int unsigned idx, input int unsigned width);
    return (8 - idx) * width;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out signal bundle of conv_window_gen.
// The slave modport is the window generator; the master is the pixel source.
interface conv_window_gen_if #(
  parameter int unsigned DATA_W = 8
);

  logic                  i_start;
  logic                  i_pix_valid;
  logic [DATA_W-1:0]     i_pix;
  logic                  o_win_valid;
  logic [9*DATA_W-1:0]   o_win;
  logic                  o_frame_done;

  modport master (
    output i_start,
    output i_pix_valid,
    output i_pix,
    input  o_win_valid,
    input  o_win,
    input  o_frame_done
  );

  modport slave (
    input  i_start,
    input  i_pix_valid,
    input  i_pix,
    output o_win_valid,
    output o_win,
    output o_frame_done
  );

endinterface

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage addressed by column.
// Read is combinational so the old entry is seen before the same-edge write.
module conv_line_buffer #(
  parameter int unsigned Depth = 32,
  parameter int unsigned Width = 8,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator feeding the convolution core; push-only, no backpressure.
// Define WIN_STRIDE2_EN to emit only windows whose top-left lies on an even row and column.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned DATA_W = conv_pkg::DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_window_gen_if.slave win_if
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  logic [ColW-1:0]   col_q, col_d, cur_col;
  logic [RowW-1:0]   row_q, row_d, cur_row;
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [9*DATA_W-1:0] win_flat;
  logic              accept, emit, last_pix, stride_ok;
  logic              win_valid_q, frame_done_q;

  assign accept = win_if.i_pix_valid;

  // A start pulse retargets the same-cycle pixel to (0,0).
  assign cur_col = win_if.i_start ? '0 : col_q;
  assign cur_row = win_if.i_start ? '0 : row_q;

`ifdef WIN_STRIDE2_EN
  assign stride_ok = ~cur_row[0] & ~cur_col[0];
`else
  assign stride_ok = 1'b1;
`endif

  assign emit     = accept && (cur_row >= RowW'(2)) && (cur_col >= ColW'(2)) && stride_ok;
  assign last_pix = accept && (cur_row == RowLast) && (cur_col == ColLast);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end else if (win_if.i_start) begin
      col_d = '0;
      row_d = '0;
    end
  end

  conv_line_buffer #(
    .Depth (IMG_W),
    .Width (DATA_W)
  ) u_lb0 (
    .clk     (clk),
    .en_i    (accept),
    .addr_i  (cur_col),
    .wdata_i (win_if.i_pix),
    .rdata_o (lb0_rd)
  );

  conv_line_buffer #(
    .Depth (IMG_W),
    .Width (DATA_W)
  ) u_lb1 (
    .clk     (clk),
    .en_i    (accept),
    .addr_i  (cur_col),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
      end
      win_d[WIN_TR] = lb1_rd;
      win_d[WIN_MR] = lb0_rd;
      win_d[WIN_BR] = win_if.i_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= emit;
      frame_done_q <= last_pix;
      win_q        <= win_d;
    end
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < 9; i++) begin
      win_flat[win_lsb(i, DATA_W) +: DATA_W] = win_q[i];
    end
  end

  assign win_if.o_win        = win_flat;
  assign win_if.o_win_valid  = win_valid_q;
  assign win_if.o_frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomised self-checking bench for conv_window_gen on a 4x4 image.
// A frame-image model derives each expected window directly from pixel coordinates.
module tb_conv_window_gen;

  localparam int W = 4;
  localparam int H = 4;
`ifdef WIN_STRIDE2_EN
  localparam int NWIN = 1;
`else
  localparam int NWIN = 4;
`endif
  localparam logic [71:0] FIRST_WIN = 72'h000102_040506_08090A;
  localparam logic [71:0] LAST_WIN  = 72'h050607_090A0B_0D0E0F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_gen_if #(.DATA_W(8)) win_if ();

  conv_window_gen #(
    .IMG_W  (W),
    .IMG_H  (H),
    .DATA_W (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .win_if (win_if)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] img [H][W];
  int mr, mc;
  logic last_emit;
  logic [71:0] last_win;
  logic [71:0] win_log [$];
  int n_done;
  logic [71:0] tmp;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [71:0] ref_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) begin
      w[(8 - i)*8 +: 8] = img[r - 2 + i/3][c - 2 + i%3];
    end
    return w;
  endfunction

  task automatic reset_model();
    mr = 0;
    mc = 0;
    last_emit = 1'b0;
    last_win = '0;
  endtask

  task automatic clear_log();
    win_log.delete();
    n_done = 0;
  endtask

  task automatic cycle(input logic st, input logic vl, input logic [7:0] px);
    logic ev, ed;
    logic [71:0] ew;
    win_if.i_start     = st;
    win_if.i_pix_valid = vl;
    win_if.i_pix       = px;
    ev = 1'b0;
    ed = 1'b0;
    ew = '0;
    if (st) begin
      mr = 0;
      mc = 0;
    end
    if (vl) begin
      img[mr][mc] = px;
      ev = (mr >= 2) && (mc >= 2);
`ifdef WIN_STRIDE2_EN
      ev = ev && ((mr - 2) % 2 == 0) && ((mc - 2) % 2 == 0);
`endif
      ed = (mr == H - 1) && (mc == W - 1);
      if (ev) ew = ref_win(mr, mc);
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("win_valid", 72'(win_if.o_win_valid), 72'(ev));
    chk("frame_done", 72'(win_if.o_frame_done), 72'(ed));
    if (ev) begin
      chk("win", win_if.o_win, ew);
      win_log.push_back(win_if.o_win);
    end else if (!vl && last_emit) begin
      chk("win_hold", win_if.o_win, last_win);
    end
    if (win_if.o_frame_done) n_done++;
    if (vl) begin
      last_emit = ev;
      last_win  = ew;
    end
  endtask

  task automatic frame(input int max_gap, input logic rnd_pix);
    for (int p = 0; p < W*H; p++) begin
      int gaps;
      gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gaps; g++) cycle(1'b0, 1'b0, 8'($urandom));
      cycle(1'b0, 1'b1, rnd_pix ? 8'($urandom) : 8'(p));
    end
  endtask

  task automatic check_ramp(input string tag, input int exp_done);
    chk({tag, "_nwin"}, 72'(win_log.size()), 72'(NWIN));
    chk({tag, "_first"}, (win_log.size() > 0) ? win_log[0] : 72'hX, FIRST_WIN);
`ifndef WIN_STRIDE2_EN
    chk({tag, "_last"}, (win_log.size() > 0) ? win_log[win_log.size()-1] : 72'hX, LAST_WIN);
`endif
    chk({tag, "_ndone"}, 72'(n_done), 72'(exp_done));
  endtask

  initial begin
    win_if.i_start     = 1'b0;
    win_if.i_pix_valid = 1'b0;
    win_if.i_pix       = '0;
    reset_model();

    // Reset state
    #12;
    chk("rst_valid", 72'(win_if.o_win_valid), 72'd0);
    chk("rst_win", win_if.o_win, 72'd0);
    chk("rst_done", 72'(win_if.o_frame_done), 72'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous ramp
    clear_log();
    frame(0, 1'b0);
    check_ramp("ramp", 1);

    // Ramp with gaps
    clear_log();
    frame(3, 1'b0);
    check_ramp("gaps", 1);

    // Abort after pixel 6 with a start pulse, then a fresh ramp
    clear_log();
    for (int p = 0; p < 7; p++) cycle(1'b0, 1'b1, 8'(p));
    cycle(1'b1, 1'b0, 8'h00);
    frame(0, 1'b0);
    check_ramp("abort", 1);

    // Asynchronous reset during pixel 9
    clear_log();
    for (int p = 0; p < 9; p++) cycle(1'b0, 1'b1, 8'(p));
    win_if.i_pix_valid = 1'b1;
    win_if.i_pix       = 8'd9;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 72'(win_if.o_win_valid), 72'd0);
    chk("arst_win", win_if.o_win, 72'd0);
    chk("arst_done", 72'(win_if.o_frame_done), 72'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_win", win_if.o_win, 72'd0);
    @(negedge clk);
    win_if.i_pix_valid = 1'b0;
    rst_n = 1'b1;
    reset_model();
    frame(1, 1'b0);
    check_ramp("arst", 1);

    // Start coincident with the first pixel, mid-frame
    clear_log();
    for (int p = 0; p < 5; p++) cycle(1'b0, 1'b1, 8'(p + 20));
    cycle(1'b1, 1'b1, 8'h80);
    for (int p = 1; p < W*H; p++) cycle(1'b0, 1'b1, 8'(p));
    tmp = (win_log.size() > 0) ? win_log[0] : 72'hX;
    chk("start_tl", 72'(tmp[71:64]), 72'h80);
    chk("start_nwin", 72'(win_log.size()), 72'(NWIN));
    chk("start_ndone", 72'(n_done), 72'd1);

    // Random pixels with random gaps across back-to-back frames
    clear_log();
    for (int f = 0; f < 3; f++) frame(2, 1'b1);
    chk("rnd_nwin", 72'(win_log.size()), 72'(3*NWIN));
    chk("rnd_ndone", 72'(n_done), 72'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
